// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, MSB first.
// Produces {remainder, quotient} for the HI/LO write path, held while start_i stays high.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic                 borrow;
  logic [WIDTH-1:0]     rem_nx;
  logic [WIDTH-1:0]     quo_nx;
  logic [WIDTH-1:0]     op1_mag;
  logic [WIDTH-1:0]     op2_mag;
  logic                 abort;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;

    // A set top bit means shifted >= 2^WIDTH > divisor, so the subtract cannot borrow.
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    borrow  = ~shifted[WIDTH] & diff[WIDTH];
    rem_nx  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx  = {dvd_q[WIDTH-2:0], ~borrow};

    op1_mag = (signed_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    op2_mag = (signed_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
    abort   = annul_i | ~start_i;

    unique case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          dvd_d   = op1_mag;
          dvs_d   = op2_mag;
          rem_d   = '0;
          negq_d  = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d  = signed_i & opdata1_i[WIDTH-1];
          cnt_d   = '0;
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end

      S_BYZERO: begin
        if (abort) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end

      S_ON: begin
        if (abort) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          rem_d = rem_nx;
          dvd_d = quo_nx;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_STEP) begin
            result_d = {(negr_q ? ('0 - rem_nx) : rem_nx),
                        (negq_q ? ('0 - quo_nx) : quo_nx)};
            ready_d  = 1'b1;
            state_d  = S_END;
          end
        end
      end

      S_END: begin
        if (abort) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = S_FREE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
